// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I opcode, funct and ALU control encodings
package rv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// rtl/rv_regfile.sv - 2R1W register file with x0 tied to zero and write-through bypass
module rv_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [$clog2(NREG)-1:0] ra1,
    output logic [XLEN-1:0]         rd1,
    input  logic [$clog2(NREG)-1:0] ra2,
    output logic [XLEN-1:0]         rd2,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [XLEN-1:0]         wd
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we && wa != '0) begin
            mem_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // A same-cycle write is visible on the read ports so decode never sees stale data.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
        if (ra == '0) begin
            return '0;
        end else if (we && wa == ra) begin
            return wd;
        end else begin
            return mem_q[ra];
        end
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

endmodule

// File: rtl/rv_id_stage.sv
// rtl/rv_id_stage.sv - RV32I OP/OP-IMM decode and operand fetch with busy scoreboard
module rv_id_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op_a,
    output logic [XLEN-1:0] out_op_b,
    output logic [3:0]      out_alu_ctrl,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_op, is_imm, legal, rd_we;
    logic       rs1_used, rs2_used, hazard, accept, wb_hit;

    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] op_b;
    logic [3:0]      alu_ctrl;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_op_a_q, out_op_a_d;
    logic [XLEN-1:0] out_op_b_q, out_op_b_d;
    logic [3:0]      out_alu_ctrl_q, out_alu_ctrl_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            out_rd_we_q, out_rd_we_d;
    logic            out_illegal_q, out_illegal_d;
    logic [NREG-1:0] busy_q, busy_d;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    rv_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs1),
        .rd1   (rs1_val),
        .ra2   (rs2),
        .rd2   (rs2_val),
        .we    (wb_we),
        .wa    (wb_rd),
        .wd    (wb_data)
    );

    always_comb begin
        is_op    = (opcode == OPC_OP);
        is_imm   = (opcode == OPC_OP_IMM);
        legal    = 1'b0;
        op_b     = XLEN'(sext12(in_instr[31:20]));
        alu_ctrl = {1'b0, funct3};
        if (is_op) begin
            legal    = (funct7 == FUNCT7_ZERO) ||
                       (funct7 == FUNCT7_ALT && (funct3 == F3_ADD || funct3 == F3_SRL));
            op_b     = rs2_val;
            alu_ctrl = {in_instr[30], funct3};
        end else if (is_imm) begin
            legal = 1'b1;
            // Shift immediates carry shamt in imm[4:0]; only srai uses bit 30 as a qualifier.
            if (funct3 == F3_SLL) begin
                legal = (funct7 == FUNCT7_ZERO);
                op_b  = XLEN'(in_instr[24:20]);
            end else if (funct3 == F3_SRL) begin
                legal    = (funct7 == FUNCT7_ZERO) || (funct7 == FUNCT7_ALT);
                op_b     = XLEN'(in_instr[24:20]);
                alu_ctrl = {in_instr[30], funct3};
            end
        end
        rd_we    = legal && (rd != 5'd0);
        rs1_used = is_op || is_imm;
        rs2_used = is_op;
    end

    always_comb begin
        wb_hit = wb_we && (wb_rd != 5'd0);
        hazard = (rs1_used && busy_q[rs1] && !(wb_we && wb_rd == rs1)) ||
                 (rs2_used && busy_q[rs2] && !(wb_we && wb_rd == rs2)) ||
                 (rd_we && busy_q[rd] && !(wb_we && wb_rd == rd));
        in_ready = (!out_valid_q || out_ready) && !hazard;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_op_a_d     = out_op_a_q;
        out_op_b_d     = out_op_b_q;
        out_alu_ctrl_d = out_alu_ctrl_q;
        out_rd_d       = out_rd_q;
        out_rd_we_d    = out_rd_we_q;
        out_illegal_d  = out_illegal_q;
        if (accept) begin
            out_valid_d    = 1'b1;
            out_op_a_d     = rs1_val;
            out_op_b_d     = op_b;
            out_alu_ctrl_d = alu_ctrl;
            out_rd_d       = rd;
            out_rd_we_d    = rd_we;
            out_illegal_d  = !legal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Set is applied after clear so a WAW issue against its own retiring writer stays busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_hit) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (accept && rd_we) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_op_a_q     <= '0;
            out_op_b_q     <= '0;
            out_alu_ctrl_q <= '0;
            out_rd_q       <= '0;
            out_rd_we_q    <= 1'b0;
            out_illegal_q  <= 1'b0;
            busy_q         <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_op_a_q     <= out_op_a_d;
            out_op_b_q     <= out_op_b_d;
            out_alu_ctrl_q <= out_alu_ctrl_d;
            out_rd_q       <= out_rd_d;
            out_rd_we_q    <= out_rd_we_d;
            out_illegal_q  <= out_illegal_d;
            busy_q         <= busy_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_op_a     = out_op_a_q;
    assign out_op_b     = out_op_b_q;
    assign out_alu_ctrl = out_alu_ctrl_q;
    assign out_rd       = out_rd_q;
    assign out_rd_we    = out_rd_we_q;
    assign out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_rv_id_stage.sv
// tb/tb_rv_id_stage.sv - directed self-checking bench for rv_id_stage
module tb_rv_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op_a;
    logic [31:0] out_op_b;
    logic [3:0]  out_alu_ctrl;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;

    rv_id_stage #(.XLEN(32), .NREG(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op_a     (out_op_a),
        .out_op_b     (out_op_b),
        .out_alu_ctrl (out_alu_ctrl),
        .out_rd       (out_rd),
        .out_rd_we    (out_rd_we),
        .out_illegal  (out_illegal),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_we = 1'b1; wb_rd = r; wb_data = d;
        tick();
        wb_we = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] ctrl, input logic [4:0] rd, input logic rd_we);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_op_a"},  out_op_a, a);
        check({tag, "_op_b"},  out_op_b, b);
        check({tag, "_ctrl"},  32'(out_alu_ctrl), 32'(ctrl));
        check({tag, "_rd"},    32'(out_rd), 32'(rd));
        check({tag, "_rd_we"}, 32'(out_rd_we), 32'(rd_we));
        check({tag, "_ill"},   32'(out_illegal), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b1;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_op_a", out_op_a, 32'h0);
        check("rst_op_b", out_op_b, 32'h0);
        check("rst_ctrl_rd", {23'd0, out_alu_ctrl, out_rd}, 32'h0);
        check("rst_we_ill", {30'd0, out_rd_we, out_illegal}, 32'h0);
        check("rst_busy", dut.busy_q, 32'h0);
        rst_n = 1'b1;
        tick();

        wb(5'd1, 32'd5);
        wb(5'd2, 32'd3);

        // add x3,x1,x2
        in_valid = 1'b1; in_instr = 32'h002081B3;
        #1 check("add_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_out("add", 32'd5, 32'd3, 4'b0000, 5'd3, 1'b1);
        check("add_busy", dut.busy_q, 32'h0000_0008);

        // sub x4,x3,x1 stalls on busy x3 until its writeback bypasses in
        in_valid = 1'b1; in_instr = 32'h40118233;
        #1 check("sub_stall", 32'(in_ready), 32'd0);
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("sub_still_stall", 32'(in_ready), 32'd0);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'd8;
        #1 check("sub_bypass_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; wb_we = 1'b0;
        chk_out("sub", 32'd8, 32'd5, 4'b1000, 5'd4, 1'b1);
        check("sub_busy", dut.busy_q, 32'h0000_0010);

        wb(5'd1, 32'hFFFF_FFF0);

        // srai x5,x1,4 then addi x6,x0,-1 back to back; x0 write in same cycle must be ignored
        in_valid = 1'b1; in_instr = 32'h4040D293;
        tick();
        chk_out("srai", 32'hFFFF_FFF0, 32'd4, 4'b1101, 5'd5, 1'b1);
        in_instr = 32'hFFF00313;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
        #1 check("addi_ready", 32'(in_ready), 32'd1);
        tick();
        wb_we = 1'b0;
        chk_out("addi", 32'h0, 32'hFFFF_FFFF, 4'b0000, 5'd6, 1'b1);
        check("addi_busy", dut.busy_q, 32'h0000_0070);

        // backpressure: add x7,x2,x2 waits while the addi bundle is held
        out_ready = 1'b0; in_instr = 32'h002103B3;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_ready", 32'(in_ready), 32'd0);
            tick();
            check("hold_op_b", out_op_b, 32'hFFFF_FFFF);
            check("hold_rd", 32'(out_rd), 32'd6);
        end
        out_ready = 1'b1;
        #1 check("release_ready", 32'(in_ready), 32'd1);
        tick();
        chk_out("add7", 32'd3, 32'd3, 4'b0000, 5'd7, 1'b1);

        // illegal encodings
        in_instr = 32'h0000006F;
        tick();
        check("jal_ill", 32'(out_illegal), 32'd1);
        check("jal_rd_we", 32'(out_rd_we), 32'd0);
        check("jal_busy", dut.busy_q, 32'h0000_00F0);
        in_instr = 32'h4020F433;
        tick();
        check("alt_and_valid", 32'(out_valid), 32'd1);
        check("alt_and_ill", 32'(out_illegal), 32'd1);
        check("alt_and_rd_we", 32'(out_rd_we), 32'd0);
        check("alt_and_busy", dut.busy_q, 32'h0000_00F0);

        // async reset with a held bundle and busy[3]
        in_instr = 32'h002081B3;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pre_rst_busy3", 32'(dut.busy_q[3]), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_valid", 32'(out_valid), 32'd0);
        check("async_busy", dut.busy_q, 32'h0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h40118233;
        #1 check("post_rst_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_out("post_rst_sub", 32'h0, 32'h0, 4'b1000, 5'd4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
